// File: rtl/mem_axi_reg_slice_if.sv
`timescale 1ns/1ps
// Five-channel AXI4 bundle used on both sides of mem_axi_reg_slice.
// ADDR_WIDTH differs between the upstream (32) and downstream (28) instances.
interface mem_axi_reg_slice_if #(
    parameter int unsigned ID_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/mem_axi_reg_slice.sv
`timescale 1ns/1ps
// Full-throughput AXI4 register slice to the memory controller: every channel goes
// through a 2-entry skid stage, and AW/AR addresses are cut down to the 28-bit window.

module mem_axi_reg_slice_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] skid_data;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;
    logic             accept_c;
    logic             drain_c;

    assign accept_c = in_valid & in_ready;
    assign drain_c  = out_valid & out_ready;

    // Next state and register load enables
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept_c && drain_c) begin
                    load_main = 1'b1;
                end else if (accept_c) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (drain_c) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain_c) begin
                    state_d        = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake flags are flops so no ready/valid path crosses the stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d != FULL);
            out_valid <= (state_d != EMPTY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            if (load_main) begin
                out_data <= main_from_skid ? skid_data : in_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end
endmodule

module mem_axi_reg_slice #(
    parameter int unsigned ID_WIDTH     = 5,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned S_ADDR_WIDTH = 32,
    parameter int unsigned M_ADDR_WIDTH = 28
) (
    input  logic                 aclk,
    input  logic                 areset,
    mem_axi_reg_slice_if.slave   s,
    mem_axi_reg_slice_if.master  m
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned AX_WIDTH   = ID_WIDTH + M_ADDR_WIDTH + 8 + 3 + 2;
    localparam int unsigned W_WIDTH    = DATA_WIDTH + STRB_WIDTH + 1;
    localparam int unsigned B_WIDTH    = ID_WIDTH + 2;
    localparam int unsigned R_WIDTH    = ID_WIDTH + DATA_WIDTH + 2 + 1;

    logic [AX_WIDTH-1:0] aw_in;
    logic [AX_WIDTH-1:0] aw_out;
    logic [W_WIDTH-1:0]  w_in;
    logic [W_WIDTH-1:0]  w_out;
    logic [B_WIDTH-1:0]  b_in;
    logic [B_WIDTH-1:0]  b_out;
    logic [AX_WIDTH-1:0] ar_in;
    logic [AX_WIDTH-1:0] ar_out;
    logic [R_WIDTH-1:0]  r_in;
    logic [R_WIDTH-1:0]  r_out;

    // Upper address bits are zero by upstream decode and are simply dropped
    assign aw_in = {s.awid, s.awaddr[M_ADDR_WIDTH-1:0], s.awlen, s.awsize, s.awburst};
    assign ar_in = {s.arid, s.araddr[M_ADDR_WIDTH-1:0], s.arlen, s.arsize, s.arburst};
    assign w_in  = {s.wdata, s.wstrb, s.wlast};
    assign b_in  = {m.bid, m.bresp};
    assign r_in  = {m.rid, m.rdata, m.rresp, m.rlast};

    assign {m.awid, m.awaddr, m.awlen, m.awsize, m.awburst} = aw_out;
    assign {m.arid, m.araddr, m.arlen, m.arsize, m.arburst} = ar_out;
    assign {m.wdata, m.wstrb, m.wlast}                      = w_out;
    assign {s.bid, s.bresp}                                 = b_out;
    assign {s.rid, s.rdata, s.rresp, s.rlast}               = r_out;

    if (S_ADDR_WIDTH > M_ADDR_WIDTH) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^{s.awaddr[S_ADDR_WIDTH-1:M_ADDR_WIDTH],
                                  s.araddr[S_ADDR_WIDTH-1:M_ADDR_WIDTH]};
    end

    mem_axi_reg_slice_stage #(.WIDTH(AX_WIDTH)) u_aw (
        .clk(aclk), .rst(areset),
        .in_valid(s.awvalid), .in_ready(s.awready), .in_data(aw_in),
        .out_valid(m.awvalid), .out_ready(m.awready), .out_data(aw_out)
    );

    mem_axi_reg_slice_stage #(.WIDTH(W_WIDTH)) u_w (
        .clk(aclk), .rst(areset),
        .in_valid(s.wvalid), .in_ready(s.wready), .in_data(w_in),
        .out_valid(m.wvalid), .out_ready(m.wready), .out_data(w_out)
    );

    mem_axi_reg_slice_stage #(.WIDTH(AX_WIDTH)) u_ar (
        .clk(aclk), .rst(areset),
        .in_valid(s.arvalid), .in_ready(s.arready), .in_data(ar_in),
        .out_valid(m.arvalid), .out_ready(m.arready), .out_data(ar_out)
    );

    // Response channels run memory-to-SoC
    mem_axi_reg_slice_stage #(.WIDTH(B_WIDTH)) u_b (
        .clk(aclk), .rst(areset),
        .in_valid(m.bvalid), .in_ready(m.bready), .in_data(b_in),
        .out_valid(s.bvalid), .out_ready(s.bready), .out_data(b_out)
    );

    mem_axi_reg_slice_stage #(.WIDTH(R_WIDTH)) u_r (
        .clk(aclk), .rst(areset),
        .in_valid(m.rvalid), .in_ready(m.rready), .in_data(r_in),
        .out_valid(s.rvalid), .out_ready(s.rready), .out_data(r_out)
    );
endmodule
